imm_instr_encoder: RTL and testbench
====================================

// Module: imm_instr_encoder
// PURPOSE
//  Inverse of the ID-stage immediate extraction. Packs a 64-bit sign-extended immediate plus register/funct
//  fields into a 32-bit RV instruction word for R/I/S/B/U/J formats. 2-stage valid/ready pipeline; flags
//  immediates not representable in the chosen format. Used by the debug program-buffer / self-test
//  instruction injector ahead of IF.
// PARAMETERS
//  CNT_W   16  width of saturating ok/err handshake counters
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   synchronous, active-high reset
//  flush      in   1   sync: drop all in-flight entries (counters kept)
//  in_valid   in   1   request valid
//  in_ready   out  1   encoder can accept this cycle
//  in_fmt     in   3   0=R 1=I 2=S 3=B 4=U 5=J, 6-7 illegal
//  in_opcode  in   7   opcode[6:0]
//  in_rd      in   5   rd (R/I/U/J)
//  in_rs1     in   5   rs1 (R/I/S/B)
//  in_rs2     in   5   rs2 (R/S/B)
//  in_funct3  in   3   funct3 (R/I/S/B)
//  in_funct7  in   7   funct7 (R only)
//  in_imm     in   64  sign-extended byte immediate, as produced by ID stage
//  out_valid  out  1   encoded word valid
//  out_ready  in   1   consumer accepts
//  out_instr  out  32  encoded instruction; 32'h0 when out_err
//  out_err    out  1   immediate/format/opcode not encodable
//  cnt_ok     out  CNT_W  saturating count of out handshakes with out_err=0
//  cnt_err    out  CNT_W  saturating count of out handshakes with out_err=1
// BEHAVIOUR
//  - Reset: in_ready=1 after reset, out_valid=0, out_instr=0, out_err=0, cnt_ok=cnt_err=0, all stage valids 0.
//  - Handshake: transfer on valid&&ready, both ends. s1_adv = !s2_v || out_ready; in_ready = !s1_v || s1_adv.
//    in_ready must not depend on in_valid.
//  - Latency 2 clk accept->out_valid; throughput 1/clk with out_ready=1. Holds up to 2 entries.
//  - out_instr/out_err stay stable while out_valid && !out_ready.
//  - Stage1 registers the fields plus a range-check result. Stage2 registers the packed word.
//  - Range rules (bits marked "equal" must all equal each other):
//    I,S: imm[63:11] equal
//    B:   imm[0]=0 and imm[63:12] equal
//    U:   imm[11:0]=0 and imm[63:31] equal
//    J:   imm[0]=0 and imm[63:20] equal
//    R:   imm ignored
//  - Also err when fmt is 6/7 or opcode[1:0]!=2'b11.
//  - Packing:
//    I: imm[11:0]|rs1|f3|rd|op
//    S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
//    B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
//    U: imm[31:12]|rd|op
//    J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
//    R: f7|rs2|rs1|f3|rd|op
//  - Counters: +1 on each out handshake, selected by out_err; saturate at all-ones, never wrap.
//  - flush: clears s1/s2 valids the next edge. An input handshake in the same cycle as flush is dropped.
//    flush has priority over all advances. A counter still counts a handshake that completes in the flush cycle.
//  - rst has priority over flush and any handshake; mid-stream reset discards entries, no output produced.
//  - Simultaneous: s2 drained and s1 refilled in the same cycle must not lose or duplicate an entry.
// STRUCTURE
//  - Shared package (rv_isa_pkg): IMM_FMT_R..J localparams, OPC_* opcode constants, instruction field
//    position constants. Shared with the immediate extractor.
//  - One sub-module: imm_range_check (comb; fmt+imm -> ok). Pipeline and packing stay in the top.
// TESTING
//  1 I, op=7'h13, rd=1, rs1=0, f3=0, imm=-1 -> out_instr=32'hFFF00093, err=0, 2 clk after accept.
//  2 S, op=7'h23, rs1=1, rs2=2, f3=2, imm=8 -> 32'h0020A423. B, op=7'h63, rs1=rs2=0, imm=-4 -> 32'hFE000EE3.
//  3 U, op=7'h37, rd=5, imm=64'h12345000 -> 32'h123452B7. J, op=7'h6F, rd=1, imm=64'h800 -> 32'h001000EF.
//  4 I with imm=2048; B with imm=3; fmt=7 -> each out_err=1, out_instr=0, cnt_err=3.
//  5 out_ready=0 for 6 clk while 4 requests are offered -> 2 accepted, in_ready=0, output stable.
//    Then release -> all 4 out, in order, no dup.
//  6 flush with 2 in flight -> out_valid=0 next clk; counters unchanged. rst mid-stream -> all outputs
//    at reset values. Force cnt_ok to saturation -> it holds all-ones.

Source files
------------

// File: rtl/rv_isa_pkg.sv
// RV32 instruction-format constants shared by the immediate extractor and encoder.
package rv_isa_pkg;

    localparam logic [2:0] IMM_FMT_R = 3'd0;
    localparam logic [2:0] IMM_FMT_I = 3'd1;
    localparam logic [2:0] IMM_FMT_S = 3'd2;
    localparam logic [2:0] IMM_FMT_B = 3'd3;
    localparam logic [2:0] IMM_FMT_U = 3'd4;
    localparam logic [2:0] IMM_FMT_J = 3'd5;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned F3_LSB  = 12;
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS2_LSB = 20;
    localparam int unsigned F7_LSB  = 25;

    function automatic logic fmt_legal(input logic [2:0] fmt);
        return fmt <= IMM_FMT_J;
    endfunction

endpackage

// File: rtl/imm_range_check.sv
// Checks that a sign-extended immediate fits the bit budget of the given format.
module imm_range_check
    import rv_isa_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [63:0] imm,
    output logic        ok
);

    // "All upper bits equal" is the sign-extension test for each width.
    always_comb begin
        ok = 1'b0;
        case (fmt)
            IMM_FMT_R:            ok = 1'b1;
            IMM_FMT_I, IMM_FMT_S: ok = (&imm[63:11]) || !(|imm[63:11]);
            IMM_FMT_B:            ok = !imm[0] && ((&imm[63:12]) || !(|imm[63:12]));
            IMM_FMT_U:            ok = !(|imm[11:0]) && ((&imm[63:31]) || !(|imm[63:31]));
            IMM_FMT_J:            ok = !imm[0] && ((&imm[63:20]) || !(|imm[63:20]));
            default:              ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/imm_instr_encoder.sv
// Packs immediate and register/funct fields into a 32-bit RV instruction word
// through a two-stage valid/ready pipeline, flagging unencodable requests.
module imm_instr_encoder
    import rv_isa_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [63:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_err
);

    logic        s1_v, s2_v, s1_adv, in_fire, out_fire, imm_ok, in_err;
    logic [2:0]  s1_fmt, s1_f3;
    logic [6:0]  s1_op, s1_f7;
    logic [4:0]  s1_rd, s1_rs1, s1_rs2;
    logic [31:0] s1_imm;
    logic        s1_err;
    logic [31:0] pack_w, s2_instr;
    logic        s2_err;

    assign s1_adv   = !s2_v || out_ready;
    assign in_ready = !s1_v || s1_adv;
    assign in_fire  = in_valid && in_ready && !flush;
    assign out_fire = s2_v && out_ready;

    assign out_valid = s2_v;
    assign out_instr = s2_instr;
    assign out_err   = s2_err;

    imm_range_check u_range_check (
        .fmt (in_fmt),
        .imm (in_imm),
        .ok  (imm_ok)
    );

    assign in_err = !imm_ok || !fmt_legal(in_fmt) || (in_opcode[1:0] != 2'b11);

    // Stage-1 payload only matters while s1_v is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_fmt <= in_fmt;
            s1_op  <= in_opcode;
            s1_rd  <= in_rd;
            s1_rs1 <= in_rs1;
            s1_rs2 <= in_rs2;
            s1_f3  <= in_funct3;
            s1_f7  <= in_funct7;
            s1_imm <= in_imm[31:0];
            s1_err <= in_err;
        end
    end

    always_comb begin
        pack_w = '0;
        case (s1_fmt)
            IMM_FMT_R: pack_w = {s1_f7, s1_rs2, s1_rs1, s1_f3, s1_rd, s1_op};
            IMM_FMT_I: pack_w = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op};
            IMM_FMT_S: pack_w = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_op};
            IMM_FMT_B: pack_w = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3,
                                 s1_imm[4:1], s1_imm[11], s1_op};
            IMM_FMT_U: pack_w = {s1_imm[31:12], s1_rd, s1_op};
            IMM_FMT_J: pack_w = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                                 s1_rd, s1_op};
            default:   pack_w = '0;
        endcase
        if (s1_err) pack_w = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v     <= 1'b0;
            s2_v     <= 1'b0;
            s2_instr <= '0;
            s2_err   <= 1'b0;
            cnt_ok   <= '0;
            cnt_err  <= '0;
        end else begin
            if (flush) begin
                s1_v <= 1'b0;
                s2_v <= 1'b0;
            end else begin
                // in_ready covers both "s1 empty" and "s1 moving on", so refill and drain share one update.
                if (in_ready) s1_v <= in_valid;
                if (s1_adv)   s2_v <= s1_v;
                if (s1_v && s1_adv) begin
                    s2_instr <= pack_w;
                    s2_err   <= s1_err;
                end
            end
            if (out_fire) begin
                if (s2_err) begin
                    if (cnt_err != '1) cnt_err <= cnt_err + 1'b1;
                end else begin
                    if (cnt_ok != '1) cnt_ok <= cnt_ok + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Scoreboard bench: driver pushes expected words on accept, monitor pops on each output handshake.
module tb_imm_instr_encoder;

    localparam int CW     = 4;
    localparam int CNTMAX = (1 << CW) - 1;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
    } req_t;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [2:0]    in_fmt, in_funct3;
    logic [6:0]    in_opcode, in_funct7;
    logic [4:0]    in_rd, in_rs1, in_rs2;
    logic [63:0]   in_imm;
    logic [31:0]   out_instr;
    logic [CW-1:0] cnt_ok, cnt_err;

    int checks = 0;
    int failures = 0;
    logic [32:0] exp_q[$];
    int m_ok = 0, m_err = 0;
    bit rnd_on = 0;

    imm_instr_encoder #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err),
        .cnt_ok(cnt_ok), .cnt_err(cnt_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: representability by signed value ranges, then field placement.
    function automatic logic [32:0] model(input req_t r);
        longint      v;
        logic [63:0] u;
        bit          ok;
        logic [31:0] w;
        v = r.imm;
        u = r.imm;
        case (r.fmt)
            3'd0:       ok = 1;
            3'd1, 3'd2: ok = (v >= -2048) && (v <= 2047);
            3'd3:       ok = (v % 2 == 0) && (v >= -4096) && (v <= 4095);
            3'd4:       ok = (v % 4096 == 0) && (v >= -(longint'(1) << 31)) && (v < (longint'(1) << 31));
            3'd5:       ok = (v % 2 == 0) && (v >= -1048576) && (v <= 1048575);
            default:    ok = 0;
        endcase
        if (r.op % 4 != 3) ok = 0;
        w = 32'h0;
        if (ok) begin
            case (r.fmt)
                3'd0: w = {r.f7, r.rs2, r.rs1, r.f3, r.rd, r.op};
                3'd1: w = {u[11:0], r.rs1, r.f3, r.rd, r.op};
                3'd2: w = {u[11:5], r.rs2, r.rs1, r.f3, u[4:0], r.op};
                3'd3: w = {u[12], u[10:5], r.rs2, r.rs1, r.f3, u[4:1], u[11], r.op};
                3'd4: w = {u[31:12], r.rd, r.op};
                default: w = {u[20], u[10:1], u[11], u[19:12], r.rd, r.op};
            endcase
        end
        return {!ok, w};
    endfunction

    function automatic req_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [63:0] imm);
        req_t r;
        r.fmt = fmt; r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
        r.f3 = f3; r.f7 = 7'h20; r.imm = imm;
        return r;
    endfunction

    function automatic req_t rnd_req();
        req_t        r;
        logic [31:0] x;
        longint      v;
        x = $urandom;
        r.fmt = (x % 10 == 0) ? 3'(6 + x[4]) : 3'($urandom_range(0, 5));
        x = $urandom;
        r.op  = (x[3:0] == 0) ? x[10:4] : {x[10:6], 2'b11};
        r.rd  = 5'($urandom); r.rs1 = 5'($urandom); r.rs2 = 5'($urandom);
        r.f3  = 3'($urandom); r.f7 = 7'($urandom);
        case ($urandom_range(0, 4))
            0: v = longint'(int'($urandom_range(0, 10000))) - 5000;
            1: v = longint'(int'($urandom_range(0, 4194304))) - 2097152;
            2: v = longint'(int'($urandom)) & ~longint'(4095);
            3: v = longint'(int'($urandom)) << $urandom_range(0, 33);
            default: v = {$urandom, $urandom};
        endcase
        r.imm = v;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input req_t r, input logic [32:0] expv);
        int n = 0;
        bit done = 0;
        in_fmt = r.fmt; in_opcode = r.op; in_rd = r.rd; in_rs1 = r.rs1; in_rs2 = r.rs2;
        in_funct3 = r.f3; in_funct7 = r.f7; in_imm = r.imm;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready && !rst && !flush) begin
                exp_q.push_back(expv);
                done = 1;
            end else if (++n > 200) begin
                chk("accept_timeout", 64'(n), 64'd0);
                done = 1;
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    // Monitor: scoreboard pops, stall stability, counter model.
    logic [31:0] held_instr;
    logic        held_err;
    bit          stall = 0;
    always @(negedge clk) begin
        logic [32:0] e;
        bit          eerr;
        if (rst) begin
            m_ok = 0; m_err = 0; stall = 0;
            exp_q.delete();
        end else begin
            chk("cnt_ok", 64'(cnt_ok), 64'(m_ok));
            chk("cnt_err", 64'(cnt_err), 64'(m_err));
            if (stall) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_instr", 64'(out_instr), 64'(held_instr));
                chk("stall_err", 64'(out_err), 64'(held_err));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 64'(out_instr), 64'hDEAD);
                    eerr = out_err;
                end else begin
                    e = exp_q.pop_front();
                    chk("out_instr", 64'(out_instr), 64'(e[31:0]));
                    chk("out_err", 64'(out_err), 64'(e[32]));
                    eerr = e[32];
                end
                if (eerr) m_err = (m_err == CNTMAX) ? CNTMAX : m_err + 1;
                else      m_ok  = (m_ok  == CNTMAX) ? CNTMAX : m_ok + 1;
            end
            stall      = out_valid && !out_ready && !flush;
            held_instr = out_instr;
            held_err   = out_err;
            if (flush) exp_q.delete();
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_on) begin
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        req_t r;
        int   ok0, err0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);

        // Latency: visible two edges after the accepting edge.
        send(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, -64'sd1), {1'b0, 32'hFFF00093});
        chk("lat_early", 64'(out_valid), 64'd0);
        tick();
        chk("lat_valid", 64'(out_valid), 64'd1);
        drain();

        send(mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 64'd8), {1'b0, 32'h0020A423});
        send(mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, -64'sd4), {1'b0, 32'hFE000EE3});
        send(mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 64'h12345000), {1'b0, 32'h123452B7});
        send(mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 64'h800), {1'b0, 32'h001000EF});
        drain();

        send(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 64'd2048), {1'b1, 32'h0});
        send(mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 64'd3), {1'b1, 32'h0});
        send(mk(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 64'd0), {1'b1, 32'h0});
        drain();
        chk("cnt_err_three", 64'(cnt_err), 64'd3);
        chk("cnt_ok_five", 64'(cnt_ok), 64'd5);

        // Backpressure: two entries held, third blocked, output frozen.
        out_ready = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            r = mk(3'd1, 7'h13, 5'(i), 5'd3, 5'd0, 3'd0, 64'(i * 16));
            send(r, model(r));
        end
        r = mk(3'd1, 7'h13, 5'd3, 5'd3, 5'd0, 3'd0, 64'd48);
        in_fmt = r.fmt; in_opcode = r.op; in_rd = r.rd; in_rs1 = r.rs1; in_rs2 = r.rs2;
        in_funct3 = r.f3; in_funct7 = r.f7; in_imm = r.imm; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_instr", 64'(out_instr), 64'h01018093);
            tick();
        end
        out_ready = 1'b1;
        send(r, model(r));
        r = mk(3'd1, 7'h13, 5'd4, 5'd3, 5'd0, 3'd0, 64'd64);
        send(r, model(r));
        drain();
        chk("bp_cnt_ok", 64'(cnt_ok), 64'd9);

        // Flush with two entries in flight.
        out_ready = 1'b0;
        send(mk(3'd0, 7'h33, 5'd7, 5'd8, 5'd9, 3'd0, 64'd0), model(mk(3'd0, 7'h33, 5'd7, 5'd8, 5'd9, 3'd0, 64'd0)));
        send(mk(3'd4, 7'h17, 5'd2, 5'd0, 5'd0, 3'd0, 64'h1000), model(mk(3'd4, 7'h17, 5'd2, 5'd0, 5'd0, 3'd0, 64'h1000)));
        ok0 = int'(cnt_ok); err0 = int'(cnt_err);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_cnt_ok", 64'(cnt_ok), 64'(ok0));
        chk("flush_cnt_err", 64'(cnt_err), 64'(err0));
        out_ready = 1'b1;

        rnd_on = 1;
        for (int i = 0; i < 300; i++) begin
            r = rnd_req();
            send(r, model(r));
        end
        rnd_on = 0;
        tick();
        out_ready = 1'b1;
        flush = 1'b0;
        drain();
        chk("cnt_ok_saturated", 64'(cnt_ok), 64'(CNTMAX));

        // Mid-stream reset discards entries and clears counters.
        out_ready = 1'b0;
        send(mk(3'd1, 7'h13, 5'd9, 5'd1, 5'd0, 3'd0, 64'd5), model(mk(3'd1, 7'h13, 5'd9, 5'd1, 5'd0, 3'd0, 64'd5)));
        send(mk(3'd1, 7'h13, 5'd10, 5'd1, 5'd0, 3'd0, 64'd6), model(mk(3'd1, 7'h13, 5'd10, 5'd1, 5'd0, 3'd0, 64'd6)));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_in_ready", 64'(in_ready), 64'd1);
        chk("mrst_out_instr", 64'(out_instr), 64'd0);
        chk("mrst_out_err", 64'(out_err), 64'd0);
        chk("mrst_cnt_ok", 64'(cnt_ok), 64'd0);
        chk("mrst_cnt_err", 64'(cnt_err), 64'd0);
        repeat (3) tick();
        chk("mrst_no_output", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
